// File: rtl/trace_pkg.sv
// Shared types and default sizing for the trace streamer.
// The entry struct is sized by the package default address width.
package trace_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DEPTH_DEF  = 524;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic                  wr;
  } entry_t;

endpackage

// File: rtl/trace_mem.sv
// Trace storage: simple dual-port RAM, one write port, one registered read port.
// The array is not reset so it can map onto block RAM.
module trace_mem import trace_pkg::*; #(
  parameter int W     = ADDR_W_DEF + 1,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/trace_streamer.sv
// Replays a loaded trace of read/write addresses as a valid/ready request stream.
// The next entry is prefetched on each acceptance, so the stream runs at 1 request/cycle.
module trace_streamer import trace_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [CNT_W-1:0]  ld_idx,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_wr,
  input  logic [CNT_W-1:0]  num_entries,
  input  logic              start,
  input  logic              loop_en,
  input  logic              abort,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_wr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           state, state_nx;
  logic [CNT_W-1:0] ptr, ptr_nx, n_ent, num_clamped, rd_idx;
  logic             loop_q, rd_en, accept, last, mem_we;
  logic [ADDR_W:0]  rd_data;

  assign num_clamped = (num_entries > DEPTH_C) ? DEPTH_C : num_entries;
  assign accept      = (state == S_ISSUE) && req_ready;
  assign last        = (ptr == n_ent - CNT_W'(1));
  assign mem_we      = ld_en && (ld_idx < DEPTH_C);

  trace_mem #(.W(ADDR_W + 1), .DEPTH(DEPTH), .AW(CNT_W)) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_idx  (ld_idx),
    .wr_data ({ld_wr, ld_addr}),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    rd_en    = 1'b0;
    rd_idx   = ptr;
    case (state)
      S_IDLE: begin
        if (start) begin
          ptr_nx   = '0;
          state_nx = (num_entries != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        rd_en    = 1'b1;
        state_nx = abort ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (accept) begin
          ptr_nx = last ? '0 : ptr + CNT_W'(1);
          if (!abort && (!last || loop_q)) begin
            rd_en  = 1'b1;
            rd_idx = ptr_nx;
          end
          if (last && !loop_q) state_nx = S_DONE;
        end
        if (abort) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      n_ent  <= '0;
      loop_q <= 1'b0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      ptr <= ptr_nx;
      if (state == S_IDLE && start && num_entries != '0) begin
        n_ent  <= num_clamped;
        loop_q <= loop_en;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else if (accept) begin
        if (rd_data[ADDR_W]) begin
          if (wr_cnt != '1) wr_cnt <= wr_cnt + 32'd1;
        end else begin
          if (rd_cnt != '1) rd_cnt <= rd_cnt + 32'd1;
        end
      end
    end
  end

  // Read data is undefined outside ISSUE, so the request fields are gated to zero.
  assign req_valid = (state == S_ISSUE);
  assign req_addr  = req_valid ? rd_data[ADDR_W-1:0] : '0;
  assign req_wr    = req_valid && rd_data[ADDR_W];
  assign busy      = (state == S_FETCH) || (state == S_ISSUE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_trace_streamer.sv
// Directed bench for trace_streamer: cycle-by-cycle expectations sampled on the falling edge.
module tb_trace_streamer;
  import trace_pkg::*;

  localparam int AW = 20;
  localparam int DP = 524;
  localparam int CW = $clog2(DP + 1);

  logic          clk, rst_n, ld_en, ld_wr, start, loop_en, abort, req_ready;
  logic [CW-1:0] ld_idx, num_entries;
  logic [AW-1:0] ld_addr, req_addr;
  logic          req_valid, req_wr, busy, done;
  logic [31:0]   rd_cnt, wr_cnt;

  int total = 0;
  int bad   = 0;

  entry_t tr [3];

  trace_streamer #(.ADDR_W(AW), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_idx(ld_idx), .ld_addr(ld_addr),
    .ld_wr(ld_wr), .num_entries(num_entries), .start(start), .loop_en(loop_en),
    .abort(abort), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr(req_wr), .busy(busy), .done(done), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input entry_t e);
    chk({tag, ".valid"}, {31'd0, req_valid}, 32'd1);
    chk({tag, ".addr"},  {12'd0, req_addr},  {12'd0, e.addr});
    chk({tag, ".wr"},    {31'd0, req_wr},    {31'd0, e.wr});
  endtask

  task automatic chk_done(input string tag);
    chk({tag, ".done"},  {31'd0, done},      32'd1);
    chk({tag, ".valid"}, {31'd0, req_valid}, 32'd0);
    chk({tag, ".busy"},  {31'd0, busy},      32'd0);
  endtask

  task automatic load(input logic [CW-1:0] idx, input entry_t e);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = idx; ld_addr = e.addr; ld_wr = e.wr;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Returns at the falling edge of cycle 1 (start is sampled at the end of cycle 0).
  task automatic go(input logic [CW-1:0] n, input logic lp);
    @(negedge clk);
    num_entries = n; loop_en = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    tr[0] = '{addr: 20'h00010, wr: 1'b0};
    tr[1] = '{addr: 20'h0abcd, wr: 1'b1};
    tr[2] = '{addr: 20'hfffff, wr: 1'b0};
    rst_n = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_addr = '0; ld_wr = 1'b0;
    num_entries = '0; start = 1'b0; loop_en = 1'b0; abort = 1'b0; req_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst.valid", {31'd0, req_valid}, 32'd0);
    chk("rst.addr",  {12'd0, req_addr},  32'd0);
    chk("rst.busy",  {31'd0, busy},      32'd0);
    chk("rst.done",  {31'd0, done},      32'd0);
    chk("rst.rd",    rd_cnt,             32'd0);
    chk("rst.wr",    wr_cnt,             32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) load(CW'(i), tr[i]);

    // basic 3-entry stream, consumer always ready
    go(3, 1'b0);
    chk("t1.c1.busy",  {31'd0, busy},      32'd1);
    chk("t1.c1.valid", {31'd0, req_valid}, 32'd0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk_req($sformatf("t1.c%0d", c), tr[c-2]);
    end
    @(negedge clk);
    chk_done("t1.c5");
    chk("t1.rd", rd_cnt, 32'd2);
    chk("t1.wr", wr_cnt, 32'd1);
    @(negedge clk);
    chk("t1.c6.done", {31'd0, done}, 32'd0);

    // back-pressure on entry 1
    go(3, 1'b0);
    @(negedge clk);
    chk_req("t2.c2", tr[0]);
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      chk_req($sformatf("t2.c%0d", c), tr[1]);
      req_ready = (c == 7);
    end
    @(negedge clk);
    chk_req("t2.c8", tr[2]);
    @(negedge clk);
    chk_done("t2.c9");
    chk("t2.rd", rd_cnt, 32'd2);
    chk("t2.wr", wr_cnt, 32'd1);

    // looping over 2 entries, abort on the 5th acceptance
    go(2, 1'b1);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      chk_req($sformatf("t3.c%0d", c), tr[(c-2) % 2]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_done("t3.c7");
    chk("t3.rd",    rd_cnt,          32'd3);
    chk("t3.wr",    wr_cnt,          32'd2);
    chk("t3.total", rd_cnt + wr_cnt, 32'd5);

    // empty trace
    go(0, 1'b0);
    chk_done("t4.c1");
    @(negedge clk);
    chk("t4.c2.done", {31'd0, done}, 32'd0);

    // reset while a request is pending
    req_ready = 1'b0;
    go(3, 1'b0);
    @(negedge clk);
    chk_req("t5.c2", tr[0]);
    rst_n = 1'b0;
    #1;
    chk("t5.rst.valid", {31'd0, req_valid}, 32'd0);
    chk("t5.rst.addr",  {12'd0, req_addr},  32'd0);
    chk("t5.rst.wr",    {31'd0, req_wr},    32'd0);
    chk("t5.rst.busy",  {31'd0, busy},      32'd0);
    chk("t5.rst.done",  {31'd0, done},      32'd0);
    chk("t5.rst.rd",    rd_cnt,             32'd0);
    @(negedge clk);
    chk("t5.rst2.done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5.post.done",  {31'd0, done},      32'd0);
    chk("t5.post.valid", {31'd0, req_valid}, 32'd0);
    req_ready = 1'b1;
    go(3, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk_req($sformatf("t5.replay.c%0d", c), tr[c-2]);
    end
    @(negedge clk);
    chk_done("t5.c5");

    // start while busy and out-of-range load are both ignored
    go(3, 1'b0);
    @(negedge clk);
    chk_req("t6.c2", tr[0]);
    start = 1'b1; ld_en = 1'b1; ld_idx = CW'(DP); ld_addr = 20'h12345; ld_wr = 1'b1;
    @(negedge clk);
    start = 1'b0; ld_en = 1'b0;
    chk_req("t6.c3", tr[1]);
    @(negedge clk);
    chk_req("t6.c4", tr[2]);
    @(negedge clk);
    chk_done("t6.c5");
    chk("t6.rd", rd_cnt, 32'd2);
    chk("t6.wr", wr_cnt, 32'd1);
    go(3, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk_req($sformatf("t6.replay.c%0d", c), tr[c-2]);
    end
    @(negedge clk);
    chk_done("t6.replay.c5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
